// File: rtl/ascii_display_scheduler_if.sv
// Requester/display bundle for ascii_display_scheduler.
// master: the requesters and display consumer side; slave: the scheduler.
`timescale 1ns/1ps
interface ascii_display_scheduler_if;
  logic       req0;
  logic       req1;
  logic [6:0] ascii0;
  logic [6:0] ascii1;
  logic       dp0;
  logic       dp1;
  logic       ack0;
  logic       ack1;
  logic [6:0] ascii_out;
  logic       dp_out;
  logic       blank;
  logic       busy;

  modport master (
    output req0, req1, ascii0, ascii1, dp0, dp1,
    input  ack0, ack1, ascii_out, dp_out, blank, busy
  );

  modport slave (
    input  req0, req1, ascii0, ascii1, dp0, dp1,
    output ack0, ack1, ascii_out, dp_out, blank, busy
  );
endinterface

// File: rtl/ascii_display_scheduler.sv
// ascii_display_scheduler: round-robin arbiter between two character
// requesters feeding an ASCII-to-7-segment decoder. Each granted character
// is shown for max(HOLD_TICKS,1) dwell ticks of CLK_DIV clocks each.
// Optional feature macro ASCII_SCHED_GAP_EN inserts a one-tick blank gap
// after every character so repeated identical characters stay distinct.
`timescale 1ns/1ps
module ascii_display_scheduler #(
  parameter int CLK_DIV    = 25000000,
  parameter int HOLD_TICKS = 2
) (
  input  logic                       clk50MHz,
  input  logic                       rst,
  ascii_display_scheduler_if.slave   bus
);

  localparam int             PW       = 26;
  localparam logic [PW-1:0]  DIV_M1   = PW'(CLK_DIV - 1);
  localparam int             HOLD_EFF = (HOLD_TICKS == 0) ? 1 : HOLD_TICKS;
  localparam logic [7:0]     HOLD_M1  = 8'(HOLD_EFF - 1);

`ifdef ASCII_SCHED_GAP_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHOW = 2'd1, GAP = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHOW = 2'd1} state_t;
`endif

  state_t          state_q;
  state_t          state_d;
  logic [PW-1:0]   presc_q;
  logic [7:0]      dwell_q;
  logic            last_q;      // 1 = requester 1 was granted last
  logic            grant0;
  logic            grant1;
  logic            tick;
  logic            show_done;
  logic            ack0_q;
  logic            ack1_q;
  logic [6:0]      ascii_q;
  logic            dp_q;

  assign tick      = (presc_q == DIV_M1);
  assign show_done = (state_q == SHOW) && tick && (dwell_q == HOLD_M1);

  // State register.
  always_ff @(posedge clk50MHz or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and grant decision; ties go to the requester not served last.
  always_comb begin
    state_d = state_q;
    grant0  = 1'b0;
    grant1  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req0 && (!bus.req1 || last_q)) begin
          grant0  = 1'b1;
          state_d = SHOW;
        end else if (bus.req1) begin
          grant1  = 1'b1;
          state_d = SHOW;
        end
      end
      SHOW: begin
`ifdef ASCII_SCHED_GAP_EN
        if (show_done) state_d = GAP;
`else
        if (show_done) state_d = IDLE;
`endif
      end
`ifdef ASCII_SCHED_GAP_EN
      GAP: begin
        if (tick) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Prescaler and dwell counter, both restarted on every state entry.
  always_ff @(posedge clk50MHz or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      dwell_q <= '0;
    end else if (state_q == IDLE || state_d != state_q) begin
      presc_q <= '0;
      dwell_q <= '0;
    end else begin
      presc_q <= tick ? '0 : presc_q + PW'(1);
      if (tick) dwell_q <= dwell_q + 8'd1;
    end
  end

  // Grant bookkeeping: ack pulses, latched character, round-robin pointer.
  always_ff @(posedge clk50MHz or posedge rst) begin
    if (rst) begin
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      ascii_q <= 7'h20;
      dp_q    <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      ack0_q <= grant0;
      ack1_q <= grant1;
      if (grant0) begin
        ascii_q <= bus.ascii0;
        dp_q    <= bus.dp0;
        last_q  <= 1'b0;
      end else if (grant1) begin
        ascii_q <= bus.ascii1;
        dp_q    <= bus.dp1;
        last_q  <= 1'b1;
      end
    end
  end

  assign bus.ack0      = ack0_q;
  assign bus.ack1      = ack1_q;
  assign bus.ascii_out = ascii_q;
  assign bus.dp_out    = dp_q;
  assign bus.blank     = (state_q != SHOW);
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ascii_display_scheduler.sv
// Scoreboard bench for ascii_display_scheduler: directed stimulus pushes
// expected grants; negedge monitors pop and compare on every ack.
// Instance a: CLK_DIV=4, HOLD_TICKS=2. Instance b: CLK_DIV=1, HOLD_TICKS=0.
`timescale 1ns/1ps
module tb_ascii_display_scheduler;

`ifdef ASCII_SCHED_GAP_EN
  localparam int PERIOD_A = 13;
`else
  localparam int PERIOD_A = 9;
`endif

  typedef struct {
    logic       id;
    logic [6:0] ch;
    logic       dp;
    int         len;   // expected SHOW cycles, 0 = not checked
    int         gap;   // expected cycles since previous ack, 0 = not checked
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  exp_t q_a[$];
  exp_t q_b[$];

  ascii_display_scheduler_if ifa();
  ascii_display_scheduler_if ifb();

  ascii_display_scheduler #(.CLK_DIV(4), .HOLD_TICKS(2)) dut_a (
    .clk50MHz (clk),
    .rst      (rst),
    .bus      (ifa)
  );

  ascii_display_scheduler #(.CLK_DIV(1), .HOLD_TICKS(0)) dut_b (
    .clk50MHz (clk),
    .rst      (rst),
    .bus      (ifb)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
    end
  endtask

  task automatic push_a(input logic id, input logic [6:0] ch, input logic dp,
                        input int len, input int gap);
    exp_t e;
    e.id = id; e.ch = ch; e.dp = dp; e.len = len; e.gap = gap;
    q_a.push_back(e);
  endtask

  task automatic push_b(input logic [6:0] ch, input int len);
    exp_t e;
    e.id = 1'b0; e.ch = ch; e.dp = 1'b0; e.len = len; e.gap = 0;
    q_b.push_back(e);
  endtask

  task automatic wait_ack(input bit sel_b, input string nm);
    int n = 0;
    @(negedge clk);
    while (!(sel_b ? (ifb.ack0 || ifb.ack1) : (ifa.ack0 || ifa.ack1)) && n < 60) begin
      @(negedge clk);
      n++;
    end
    check(nm, int'(n < 60), 1);
  endtask

  task automatic wait_idle_a(input string nm);
    int n = 0;
    while (ifa.busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(nm, int'(n < 100), 1);
  endtask

  // Monitor for instance a.
  exp_t cur_a;
  int   run_a = 0;
  int   since_a = -1;
  bit   in_run_a = 0;
  bit   hold_ok_a = 1;
  initial forever begin
    @(negedge clk);
    if (rst) begin
      in_run_a = 0;
      since_a  = -1;
    end else begin
      if (since_a >= 0) since_a++;
      if (ifa.ack0 || ifa.ack1) begin
        check("a_ack_onehot", int'(ifa.ack0 && ifa.ack1), 0);
        check("a_ack_expected", int'(q_a.size() > 0), 1);
        if (q_a.size() > 0) begin
          cur_a = q_a.pop_front();
          check("a_ack_id", int'(ifa.ack1), int'(cur_a.id));
          check("a_ascii", int'(ifa.ascii_out), int'(cur_a.ch));
          check("a_dp", int'(ifa.dp_out), int'(cur_a.dp));
          if (cur_a.gap > 0) check("a_period", since_a, cur_a.gap);
          in_run_a  = 1;
          run_a     = 0;
          hold_ok_a = 1;
        end
        since_a = 0;
      end
      if (in_run_a) begin
        if (!ifa.blank && ifa.busy) begin
          run_a++;
          if (ifa.ascii_out != cur_a.ch || ifa.dp_out != cur_a.dp) hold_ok_a = 0;
        end else begin
          in_run_a = 0;
          if (cur_a.len > 0) check("a_show_len", run_a, cur_a.len);
          check("a_show_hold", int'(hold_ok_a), 1);
        end
      end
    end
  end

  // Monitor for instance b.
  exp_t cur_b;
  int   run_b = 0;
  bit   in_run_b = 0;
  initial forever begin
    @(negedge clk);
    if (rst) begin
      in_run_b = 0;
    end else begin
      if (ifb.ack0 || ifb.ack1) begin
        check("b_ack_expected", int'(q_b.size() > 0), 1);
        if (q_b.size() > 0) begin
          cur_b    = q_b.pop_front();
          check("b_ascii", int'(ifb.ascii_out), int'(cur_b.ch));
          in_run_b = 1;
          run_b    = 0;
        end
      end
      if (in_run_b) begin
        if (!ifb.blank && ifb.busy) run_b++;
        else begin
          in_run_b = 0;
          check("b_show_len", run_b, cur_b.len);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ifa.req0 = 0; ifa.req1 = 0; ifa.ascii0 = 7'h00; ifa.ascii1 = 7'h00;
    ifa.dp0 = 0; ifa.dp1 = 0;
    ifb.req0 = 0; ifb.req1 = 0; ifb.ascii0 = 7'h00; ifb.ascii1 = 7'h00;
    ifb.dp0 = 0; ifb.dp1 = 0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_ascii", int'(ifa.ascii_out), 'h20);
    check("rst_dp", int'(ifa.dp_out), 0);
    check("rst_blank", int'(ifa.blank), 1);
    check("rst_busy", int'(ifa.busy), 0);
    check("rst_acks", int'({ifa.ack0, ifa.ack1}), 0);
    check("rst_b_ascii", int'(ifb.ascii_out), 'h20);

    // Single grant with decimal point
    rst = 0;
    ifa.ascii0 = 7'h41; ifa.dp0 = 1;
    push_a(1'b0, 7'h41, 1'b1, 8, 0);
    ifa.req0 = 1;
    wait_ack(0, "t1_ack_wait");
    ifa.req0 = 0;
    wait_idle_a("t1_idle_wait");

    // Round-robin with both requesters held
    rst = 1;
    @(negedge clk);
    rst = 0;
    ifa.ascii0 = 7'h30; ifa.dp0 = 0;
    ifa.ascii1 = 7'h31; ifa.dp1 = 1;
    push_a(1'b0, 7'h30, 1'b0, 8, 0);
    push_a(1'b1, 7'h31, 1'b1, 8, PERIOD_A);
    push_a(1'b0, 7'h30, 1'b0, 8, PERIOD_A);
    push_a(1'b1, 7'h31, 1'b1, 8, PERIOD_A);
    ifa.req0 = 1; ifa.req1 = 1;
    repeat (4) wait_ack(0, "t2_ack_wait");
    ifa.req0 = 0; ifa.req1 = 0;
    wait_idle_a("t2_idle_wait");

    // Reset mid-SHOW aborts, then requester 1 granted right after release
    rst = 1;
    @(negedge clk);
    rst = 0;
    ifa.ascii1 = 7'h52; ifa.dp1 = 0;
    push_a(1'b1, 7'h52, 1'b0, 0, 0);
    ifa.req1 = 1;
    wait_ack(0, "t3_ack_wait");
    repeat (3) @(negedge clk);
    rst = 1;
    #1;
    check("t3_abort_ascii", int'(ifa.ascii_out), 'h20);
    check("t3_abort_blank", int'(ifa.blank), 1);
    check("t3_abort_busy", int'(ifa.busy), 0);
    check("t3_abort_acks", int'({ifa.ack0, ifa.ack1}), 0);
    @(negedge clk);
    push_a(1'b1, 7'h52, 1'b0, 8, 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("t3_ack_after_release", int'(ifa.ack1), 1);
    ifa.req1 = 0;
    ifa.ascii1 = 7'h7A;
    repeat (2) @(negedge clk);
    ifa.ascii0 = 7'h55; ifa.req0 = 1;
    repeat (2) @(negedge clk);
    ifa.req0 = 0;
    wait_idle_a("t3_idle_wait");
    repeat (3) @(negedge clk);
    check("t3_retain_ascii", int'(ifa.ascii_out), 'h52);
    check("t3_idle_blank", int'(ifa.blank), 1);
    check("t3_idle_busy", int'(ifa.busy), 0);
    check("t3_queue_empty", q_a.size(), 0);

    // Minimal dwell: one-cycle SHOW, input change during SHOW ignored
    ifb.ascii0 = 7'h61;
    push_b(7'h61, 1);
    ifb.req0 = 1;
    wait_ack(1, "t4_ack_wait");
    ifb.ascii0 = 7'h62;
    push_b(7'h62, 1);
    @(negedge clk);
    check("t4_retain_ascii", int'(ifb.ascii_out), 'h61);
    check("t4_after_show_blank", int'(ifb.blank), 1);
    wait_ack(1, "t4_ack2_wait");
    ifb.req0 = 0;
    repeat (4) @(negedge clk);
    check("t4_last_ascii", int'(ifb.ascii_out), 'h62);
    check("t4_queue_empty", q_b.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
